handshake_join3: RTL and testbench
==================================

Name: handshake_join3

Overview:
- Three-input synchronous join stage that sits directly upstream of the synchronous Muller C-element.
- Accepts one token per input channel over independent valid/ready handshakes and holds each token until all three have arrived.
- Exports the per-channel arrival vector as `arrived[2:0]`, which is the C-element's `data_input`.
- Emits the three joined tokens as one output beat over a valid/ready handshake, then clears for the next round.

Parameters:
- DATA_W, 8, width of each input channel's data word.
- CNT_W, 16, width of the completed-join counter.
- TIMEOUT_CYCLES, 64, partial-arrival watchdog limit in cycles. Used only when the optional feature is compiled in.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- s0_valid  input  1  channel 0 token valid.
- s0_ready  output  1  channel 0 can accept a token.
- s0_data  input  DATA_W  channel 0 data.
- s1_valid, s1_ready, s1_data  as channel 0, for channel 1.
- s2_valid, s2_ready, s2_data  as channel 0, for channel 2.
- m_valid  output  1  joined beat valid.
- m_ready  input  1  downstream accepts the joined beat.
- m_data  output  3*DATA_W  joined data, packed {s2, s1, s0}.
- arrived  output  3  per-channel captured flags; bit i = channel i holds a token (feeds the C-element `data_input`).
- join_count  output  CNT_W  number of completed output transfers.

Behaviour:
- Reset (resetn=0, takes effect immediately, asynchronous):
  - arrived=3'b000, m_valid=0, m_data=0, join_count=0.
  - All s*_ready go high on the first clock after resetn deasserts.
  - Reset mid-round discards any captured tokens and any pending output beat.
- Channel i capture:
  - s{i}_ready = ~arrived[i] (registered flag, combinational inversion).
  - On an edge with s{i}_valid & s{i}_ready: arrived[i] is set to 1 and s{i}_data is stored in hold register i.
  - A channel cannot capture twice in one round.
  - Valid asserted while ready is low is ignored; the source must hold valid and data stable until ready.
- Join condition: join_fire = (arrived == 3'b111) & (~m_valid | m_ready).
- On join_fire at an edge:
  - m_data <= {hold2, hold1, hold0}, m_valid <= 1, arrived <= 3'b000.
  - All readies reassert the following cycle.
- Latency: m_valid asserts 1 cycle after the edge that captured the last of the three tokens.
  - Same-cycle capture of all three tokens is legal; m_valid rises on the next edge.
- Output handshake:
  - m_valid & m_ready at an edge completes the transfer and increments join_count.
  - join_count wraps modulo 2^CNT_W from all-ones to 0.
  - With no new join, m_valid then drops to 0.
- Back-to-back joins: if a transfer completes on the same edge as join_fire, m_valid stays 1 and m_data updates. Full throughput is one join per 2 cycles per channel.
- Output stall: m_valid=1 & m_ready=0 & arrived=111 → hold everything. No capture is possible because all readies are low.
- m_data is stable while m_valid=1 & m_ready=0.
- No combinational path from any s*_valid to m_valid, or from m_ready to any s*_ready.
- State machine, implicit in arrived/m_valid:
  - COLLECT: arrived≠111.
  - FULL: arrived=111, m_valid blocked.
  - EMIT: m_valid=1.
  - COLLECT and EMIT may overlap, since collection of the next round proceeds while the output beat waits.

Optional Feature:
- Macro: JOIN_TIMEOUT_EN.
- Defined:
  - Adds output err_timeout (1 bit) and an internal watchdog counter of width clog2(TIMEOUT_CYCLES+1).
  - The counter resets to 0 on any capture or join_fire, and also whenever arrived is 000 or 111.
  - Otherwise it increments each cycle.
  - When the counter reaches TIMEOUT_CYCLES, on that edge: arrived is cleared to 000, held tokens are discarded, err_timeout pulses high for exactly 1 cycle, and the counter returns to 0.
  - err_timeout resets to 0.
- Not defined: no err_timeout port, no watchdog logic; partial arrivals wait indefinitely.

Test Plan:
- Reset: resetn=0 mid-round with arrived=011 → arrived=000, m_valid=0, join_count=0 immediately; all readies=1 one cycle after release.
- Staggered arrival: s0 data 0x11 at cycle 2, s1 data 0x22 at cycle 5, s2 data 0x33 at cycle 9, m_ready=1 → arrived steps 001, 011, 111; m_valid=1 at cycle 10 with m_data=0x332211; join_count=1 after cycle 10.
- Simultaneous arrival: all three valid in one cycle with 0xAA/0xBB/0xCC → m_data=0xCCBBAA one cycle later; no double capture while valid is held.
- Stall: m_ready=0 for 20 cycles after a join, then a second full round arrives → arrived=111 and readies held low; m_data unchanged; on m_ready=1, two transfers complete on consecutive edges (join_count=2).
- Wrap: CNT_W=2, 5 joins → join_count sequence 1, 2, 3, 0, 1.
- JOIN_TIMEOUT_EN, TIMEOUT_CYCLES=8: only s1 arrives → err_timeout is a 1-cycle pulse exactly 8 cycles later; arrived=000; s1_ready=1 next cycle.

Source files
------------

// File: rtl/handshake_join3_if.sv
// handshake_join3_if: three token input channels, the joined output beat and join status.
interface handshake_join3_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
);
   logic              s0_valid, s0_ready;
   logic [DATA_W-1:0] s0_data;
   logic              s1_valid, s1_ready;
   logic [DATA_W-1:0] s1_data;
   logic              s2_valid, s2_ready;
   logic [DATA_W-1:0] s2_data;
   logic                m_valid, m_ready;
   logic [3*DATA_W-1:0] m_data;
   logic [2:0]          arrived;
   logic [CNT_W-1:0]    join_count;

   modport master (
      output s0_valid, s0_data, s1_valid, s1_data, s2_valid, s2_data, m_ready,
      input  s0_ready, s1_ready, s2_ready, m_valid, m_data, arrived, join_count
   );

   modport slave (
      input  s0_valid, s0_data, s1_valid, s1_data, s2_valid, s2_data, m_ready,
      output s0_ready, s1_ready, s2_ready, m_valid, m_data, arrived, join_count
   );
endinterface

// File: rtl/handshake_join3.sv
// handshake_join3: three-channel valid/ready join whose arrival vector feeds a Muller C-element.
// Defining JOIN_TIMEOUT_EN adds a partial-arrival watchdog with an err_timeout pulse.
module handshake_join3 #(
   parameter int DATA_W         = 8,
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic resetn,
`ifdef JOIN_TIMEOUT_EN
   output logic err_timeout,
`endif
   handshake_join3_if.slave bus
);
   logic [2:0]          valid, cap, arrived_q, arrived_d;
   logic [DATA_W-1:0]   data [3];
   logic [DATA_W-1:0]   hold_q [3];
   logic [DATA_W-1:0]   hold_d [3];
   logic                m_valid_q, m_valid_d, join_fire, xfer, expire;
   logic [3*DATA_W-1:0] m_data_q, m_data_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   assign valid     = {bus.s2_valid, bus.s1_valid, bus.s0_valid};
   assign data[0]   = bus.s0_data;
   assign data[1]   = bus.s1_data;
   assign data[2]   = bus.s2_data;
   assign cap       = valid & ~arrived_q;
   assign join_fire = (&arrived_q) & (~m_valid_q | bus.m_ready);
   assign xfer      = m_valid_q & bus.m_ready;

   assign bus.s0_ready   = ~arrived_q[0];
   assign bus.s1_ready   = ~arrived_q[1];
   assign bus.s2_ready   = ~arrived_q[2];
   assign bus.m_valid    = m_valid_q;
   assign bus.m_data     = m_data_q;
   assign bus.arrived    = arrived_q;
   assign bus.join_count = cnt_q;

`ifdef JOIN_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            err_q, wd_inc;
   // The watchdog only runs while a round is partially collected and idle
   assign wd_inc      = ~(|cap | join_fire | (arrived_q == 3'b000) | (&arrived_q));
   assign expire      = wd_inc & (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
   assign wd_d        = (wd_inc & ~expire) ? wd_q + 1'b1 : '0;
   assign err_timeout = err_q;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= expire;
      end
   end
`else
   logic unused_timeout;
   assign expire         = 1'b0;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   always_comb begin
      arrived_d = (join_fire | expire) ? 3'b000 : arrived_q | cap;
      for (int i = 0; i < 3; i++) hold_d[i] = cap[i] ? data[i] : hold_q[i];
      m_valid_d = join_fire | (m_valid_q & ~bus.m_ready);
      m_data_d  = join_fire ? {hold_q[2], hold_q[1], hold_q[0]} : m_data_q;
      cnt_d     = cnt_q + CNT_W'(xfer);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         arrived_q <= '0;
         hold_q    <= '{default: '0};
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         cnt_q     <= '0;
      end else begin
         arrived_q <= arrived_d;
         hold_q    <= hold_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         cnt_q     <= cnt_d;
      end
   end
endmodule

// File: tb/tb_handshake_join3.sv
// tb_handshake_join3: random sources plus a queue-based join model checked by an output monitor.
module tb_handshake_join3;
   localparam int DW = 8;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   handshake_join3_if #(.DATA_W(DW), .CNT_W(CW)) bus ();
`ifdef JOIN_TIMEOUT_EN
   logic err_timeout;
`endif
   handshake_join3 #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk),
      .resetn(resetn),
`ifdef JOIN_TIMEOUT_EN
      .err_timeout(err_timeout),
`endif
      .bus(bus)
   );

   int tot = 0, bad = 0, nx = 0, vp = 0, rp = 0;
   logic [DW-1:0]   tokq [3][$];
   logic [3*DW-1:0] expq [$];
   logic [2:0]      v, dv, rdy_rec;
   logic [DW-1:0]   d [3];
   logic [DW-1:0]   dd [3];
   logic            mr, gen_en, mon_en, stall_prev, done;
   logic [3*DW-1:0] data_prev, e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tot++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      dv = v;
      for (int i = 0; i < 3; i++) dd[i] = d[i];
      bus.s0_valid = dv[0]; bus.s0_data = dd[0];
      bus.s1_valid = dv[1]; bus.s1_data = dd[1];
      bus.s2_valid = dv[2]; bus.s2_data = dd[2];
      bus.m_ready  = mr;
   endtask

   // One negedge: book the tokens accepted at the last posedge, then drive the next inputs
   task automatic step();
      @(negedge clk);
      for (int i = 0; i < 3; i++)
         if (dv[i] && rdy_rec[i]) begin
            tokq[i].push_back(dd[i]);
            v[i] = 1'b0;
         end
      while (tokq[0].size() > 0 && tokq[1].size() > 0 && tokq[2].size() > 0)
         expq.push_back({tokq[2].pop_front(), tokq[1].pop_front(), tokq[0].pop_front()});
      rdy_rec = {bus.s2_ready, bus.s1_ready, bus.s0_ready};
      if (gen_en) begin
         for (int i = 0; i < 3; i++)
            if (!v[i] && $urandom_range(99) < vp) begin
               v[i] = 1'b1;
               d[i] = DW'($urandom);
            end
         mr = $urandom_range(99) < rp;
      end
      drive();
   endtask

   always begin
      @(negedge clk);
      #2;
      if (mon_en) begin
         chk("join_count", bus.join_count, 64'(nx % (1 << CW)));
         if (stall_prev) begin
            chk("stall_valid", bus.m_valid, 1);
            chk("stall_data", bus.m_data, data_prev);
         end
         if (bus.m_valid && bus.m_ready) begin
            if (expq.size() == 0) chk("spurious_beat", bus.m_data, 0 - 64'd1);
            else begin
               e = expq.pop_front();
               chk("beat_data", bus.m_data, e);
            end
            nx++;
         end
         stall_prev = bus.m_valid && !bus.m_ready;
         data_prev  = bus.m_data;
      end else stall_prev = 1'b0;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      v = '0; mr = 1'b0; gen_en = 1'b0; mon_en = 1'b0; rdy_rec = '0; stall_prev = 1'b0;
      d = '{default: '0};
      drive();
      #12;
      chk("rst_arrived", bus.arrived, 0);
      chk("rst_m_valid", bus.m_valid, 0);
      chk("rst_m_data", bus.m_data, 0);
      chk("rst_count", bus.join_count, 0);
      @(negedge clk);
      resetn = 1'b1;
      step();
      chk("rst_readies", {bus.s2_ready, bus.s1_ready, bus.s0_ready}, 3'b111);
      mon_en = 1'b1;
      // staggered arrival
      mr = 1'b1;
      v[0] = 1'b1; d[0] = 8'h11; step(); step();
      chk("stag_arr1", bus.arrived, 3'b001);
      v[1] = 1'b1; d[1] = 8'h22; step(); step();
      chk("stag_arr2", bus.arrived, 3'b011);
      v[2] = 1'b1; d[2] = 8'h33; step(); step();
      chk("stag_arr3", bus.arrived, 3'b111);
      chk("stag_novalid", bus.m_valid, 0);
      step();
      chk("stag_valid", bus.m_valid, 1);
      chk("stag_data", bus.m_data, 24'h332211);
      chk("stag_clear", bus.arrived, 3'b000);
      // simultaneous arrival
      v = 3'b111; d[0] = 8'hAA; d[1] = 8'hBB; d[2] = 8'hCC;
      step(); step();
      chk("sim_arr", bus.arrived, 3'b111);
      step();
      chk("sim_valid", bus.m_valid, 1);
      chk("sim_data", bus.m_data, 24'hCCBBAA);
      step();
      // output stall with a second round queued behind it
      mr = 1'b0;
      v = 3'b111; d[0] = 8'h01; d[1] = 8'h02; d[2] = 8'h03;
      step(); step(); step();
      chk("stall_v1", bus.m_valid, 1);
      v = 3'b111; d[0] = 8'h04; d[1] = 8'h05; d[2] = 8'h06;
      step(); step();
      repeat (20) step();
      chk("stall_arr", bus.arrived, 3'b111);
      chk("stall_rdy", {bus.s2_ready, bus.s1_ready, bus.s0_ready}, 3'b000);
      chk("stall_hold", bus.m_data, 24'h030201);
      mr = 1'b1;
      step(); step();
      chk("b2b_valid", bus.m_valid, 1);
      chk("b2b_data", bus.m_data, 24'h060504);
      step();
      chk("b2b_drop", bus.m_valid, 0);
      // random traffic with varying backpressure
      gen_en = 1'b1;
      for (int s = 0; s < 6; s++) begin
         case (s)
            0: begin vp = 40; rp = 90; end
            1: begin vp = 80; rp = 50; end
            2: begin vp = 60; rp = 0; end
            3: begin vp = 30; rp = 100; end
            4: begin vp = 90; rp = 20; end
            default: begin vp = 50; rp = 70; end
         endcase
         repeat (100) step();
      end
      // drain: top up partial rounds, then wait for the scoreboard to empty
      gen_en = 1'b0; mr = 1'b1; done = 1'b0;
      for (int k = 0; k < 400 && !done; k++) begin
         step();
         for (int i = 0; i < 3; i++)
            if (tokq[i].size() == 0 && !v[i] && !dv[i] &&
                (tokq[0].size() + tokq[1].size() + tokq[2].size()) > 0) begin
               v[i] = 1'b1;
               d[i] = DW'($urandom);
            end
         done = (tokq[0].size() + tokq[1].size() + tokq[2].size()) == 0 && v == 0 && dv == 0 &&
                expq.size() == 0 && !bus.m_valid;
      end
      chk("drain_done", done, 1);
      // reset in the middle of a round
      v = 3'b011; d[0] = 8'h5A; d[1] = 8'h5B;
      step(); step();
      chk("mid_arr", bus.arrived, 3'b011);
      mon_en = 1'b0;
      v = '0;
      drive();
      for (int i = 0; i < 3; i++) tokq[i].delete();
      #3 resetn = 1'b0;
      #1;
      chk("mid_rst_arr", bus.arrived, 0);
      chk("mid_rst_valid", bus.m_valid, 0);
      chk("mid_rst_count", bus.join_count, 0);
      chk("mid_rst_data", bus.m_data, 0);
      @(negedge clk);
      resetn = 1'b1;
      step();
      chk("mid_rst_rdy", {bus.s2_ready, bus.s1_ready, bus.s0_ready}, 3'b111);
      nx = 0;
      expq.delete();
      mon_en = 1'b1;
      v = 3'b111; d[0] = 8'h77; d[1] = 8'h88; d[2] = 8'h99;
      step(); step(); step();
      chk("post_rst_data", bus.m_data, 24'h998877);
      step(); step();
      chk("post_rst_count", bus.join_count, 1);
      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end
endmodule
